// File: rtl/osc_pkg.sv
// Shared encodings for the multi-waveform oscillator: modes, register map,
// triangle direction and the byte-strobe merge helper.
package osc_pkg;

  typedef enum logic [1:0] {
    OSC_OFF = 2'd0,
    OSC_SAW = 2'd1,
    OSC_TRI = 2'd2,
    OSC_SQR = 2'd3
  } osc_mode_e;

  localparam logic [1:0] REG_DIV    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } tri_dir_e;

  // Replace only the bytes selected by wstrb; callers truncate to register width.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/osc_multi_if.sv
// valid/ready memory-bus slave port of the oscillator (CPU side is master).
interface osc_multi_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/osc_prescaler.sv
// Step-rate divider: counts 0..div and emits a one-cycle tick at div.
module osc_prescaler #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // clear wins over a pending tick so a register write drops the step
  assign tick = ~clear && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/osc_multi.sv
// Multi-waveform oscillator (saw/triangle/square) behind a valid/ready bus.
// Optional cycle-start pulse port `sync` when OSC_MULTI_SYNC_EN is defined.
module osc_multi
  import osc_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  osc_multi_if.slave       bus,
  output logic [OUT_W-1:0] out
`ifdef OSC_MULTI_SYNC_EN
  ,
  output logic             sync
`endif
);

  localparam logic [OUT_W-1:0] MAX = '1;

  logic             ready_q;
  logic [31:0]      rdata_q, rd_val;
  logic [DIV_W-1:0] div_q, div_d;
  osc_mode_e        mode_q, mode_d;
  logic [OUT_W-1:0] duty_q, duty_d;
  logic [OUT_W-1:0] phase_q, phase_d;
  logic [OUT_W-1:0] out_q, out_d;
  tri_dir_e         dir_q, dir_d;
  logic [1:0]       reg_idx;
  logic             access, wr_en, running, clear, tick;
  logic             unused_addr;

  assign reg_idx     = bus.addr[3:2];
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
  assign access      = bus.valid & ~ready_q;
  assign wr_en       = access & (|bus.wstrb);
  assign running     = (div_q != '0) && (mode_q != OSC_OFF);
  assign clear       = (wr_en && (reg_idx == REG_DIV || reg_idx == REG_CTRL)) || !running;

  osc_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .div   (div_q),
    .tick  (tick)
  );

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    div_d  = div_q;
    mode_d = mode_q;
    duty_d = duty_q;
    if (wr_en) begin
      case (reg_idx)
        REG_DIV:  div_d  = DIV_W'(apply_wstrb(32'(div_q), bus.wdata, bus.wstrb));
        REG_CTRL: mode_d = osc_mode_e'(2'(apply_wstrb(32'(mode_q), bus.wdata, bus.wstrb)));
        REG_DUTY: duty_d = OUT_W'(apply_wstrb(32'(duty_q), bus.wdata, bus.wstrb));
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_DIV:  rd_val = 32'(div_q);
      REG_CTRL: rd_val = 32'(mode_q);
      REG_DUTY: rd_val = 32'(duty_q);
      default: begin
        rd_val[OUT_W-1:0] = out_q;
        rd_val[16]        = dir_q;
        rd_val[17]        = running;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= '0;
      mode_q  <= OSC_OFF;
      duty_q  <= '0;
    end else begin
      ready_q <= access;
      rdata_q <= access ? rd_val : '0;
      div_q   <= div_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
    end
  end

  // Waveform state register
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      dir_q   <= DIR_UP;
      out_q   <= '0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
    end
  end

  // Next state: saw/square ramp with wrap, triangle bounces between 0 and MAX
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    if (clear) begin
      phase_d = '0;
      dir_d   = DIR_UP;
    end else if (tick) begin
      if (mode_q == OSC_TRI) begin
        if (dir_q == DIR_UP) begin
          phase_d = phase_q + 1'b1;
          if (phase_d == MAX) dir_d = DIR_DOWN;
        end else begin
          phase_d = phase_q - 1'b1;
          if (phase_d == '0) dir_d = DIR_UP;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (clear) begin
      out_d = '0;
    end else if (tick) begin
      if (mode_q == OSC_SQR) out_d = (phase_d < duty_q) ? MAX : '0;
      else                   out_d = phase_d;
    end
  end

  assign out         = out_q;
  assign bus.ready   = ready_q;
  assign bus.rdata   = rdata_q;

`ifdef OSC_MULTI_SYNC_EN
  logic sync_q, sync_d;

  // Pulse only when a step lands phase on 0 through a wrap, never on a clear
  always_comb begin
    sync_d = 1'b0;
    if (tick) begin
      if (mode_q == OSC_TRI) sync_d = (dir_q == DIR_DOWN) && (phase_q == OUT_W'(1));
      else                   sync_d = (phase_q == MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 1'b0;
    else       sync_q <= sync_d;
  end

  assign sync = sync_q;
`endif

endmodule

// File: tb/tb_osc_multi.sv
// Self-checking bench for osc_multi: register vectors, random bus traffic,
// waveform sequences against a tick-count model, and bus/timing corner cases.
module tb_osc_multi;
  import osc_pkg::*;

  localparam int OUT_W = 8;
  localparam int DIV_W = 32;
  localparam int MAXV  = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [OUT_W-1:0] out_w;
`ifdef OSC_MULTI_SYNC_EN
  logic             sync_w;
`endif

  osc_multi_if bus ();

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  osc_multi #(.OUT_W(OUT_W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .out   (out_w)
`ifdef OSC_MULTI_SYNC_EN
    ,
    .sync  (sync_w)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  // Called right after a negedge; returns at the negedge where ready is seen.
  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    int waited;
    if (bus.ready === 1'b1) @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = s;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.ready !== 1'b1 && waited < 16);
    r = bus.rdata;
    check("bus_latency", waited, 1);
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_r;
    bus_xfer(a, d, s, unused_r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_xfer(a, 32'h0, 4'h0, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference waveform as a function of ticks since the last clear
  function automatic int saw_val(input int n);
    return n % (MAXV + 1);
  endfunction

  function automatic int tri_val(input int n);
    int p;
    p = n % (2 * MAXV);
    return (p <= MAXV) ? p : 2 * MAXV - p;
  endfunction

  function automatic bit tri_down(input int n);
    return (n % (2 * MAXV)) >= MAXV;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[11];
    logic [31:0] r, st_exp;
    logic [31:0] m_div, m_ctrl, m_duty, mask, a, wd;
    logic [3:0]  st;
    int          errs, first, idx, mo, duty, n, k_hit;
    bit          bad;

    vecs[0]  = '{32'h0000_0000, 32'h1234_5678, 4'hF, 32'h1234_5678};
    vecs[1]  = '{32'h0000_0000, 32'hAABB_CCDD, 4'h2, 32'h1234_CC78};
    vecs[2]  = '{32'h0000_0000, 32'hAABB_CCDD, 4'h9, 32'hAA34_CCDD};
    vecs[3]  = '{32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 32'h0000_0003};
    vecs[4]  = '{32'h0000_0104, 32'h0000_0002, 4'h1, 32'h0000_0002};
    vecs[5]  = '{32'h0000_0004, 32'hFFFF_FF00, 4'hE, 32'h0000_0002};
    vecs[6]  = '{32'h0000_0008, 32'h0000_ABCD, 4'hF, 32'h0000_00CD};
    vecs[7]  = '{32'h0000_0008, 32'h0000_1122, 4'h2, 32'h0000_00CD};
    vecs[8]  = '{32'h0000_0004, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[9]  = '{32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[10] = '{32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000};

    bus_idle();
    do_reset();

    // Reset state
    check("reset_out", out_w, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_rdata", bus.rdata, 0);
`ifdef OSC_MULTI_SYNC_EN
    check("reset_sync", sync_w, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), r);
      check($sformatf("reset_reg%0d", i), r, 0);
    end

    // Register vectors: write then read back
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      rd(vecs[i].addr, r);
      check($sformatf("vec%0d_readback", i), r, vecs[i].exp);
    end

    // Random register traffic against a shadow model
    do_reset();
    m_div = 0; m_ctrl = 0; m_duty = 0;
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 3);
      a   = ($urandom & 32'hFFFF_FFF0) | 32'(idx << 2) | 32'($urandom_range(0, 3));
      wd  = $urandom;
      st  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if (st != 4'h0) begin
        wr(a, wd, st);
        mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        case (idx)
          0: m_div  = (m_div & ~mask) | (wd & mask);
          1: m_ctrl = ((m_ctrl & ~mask) | (wd & mask)) & 32'h3;
          2: m_duty = ((m_duty & ~mask) | (wd & mask)) & 32'(MAXV);
          default: ;
        endcase
      end else begin
        rd(a, r);
        case (idx)
          0: check("rand_div", r, m_div);
          1: check("rand_ctrl", r, m_ctrl);
          2: check("rand_duty", r, m_duty);
          default: check("rand_status_running", {31'b0, r[17]},
                         {31'b0, (m_div != 0) && (m_ctrl != 0)});
        endcase
      end
    end
    rd(32'h0, r); check("rand_final_div", r, m_div);
    rd(32'h4, r); check("rand_final_ctrl", r, m_ctrl);
    rd(32'h8, r); check("rand_final_duty", r, m_duty);

    // Saw, DIV=1: one step per two clocks
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'(OSC_SAW), 4'hF);
    errs = 0; first = -1; n = 0;
    for (int k = 0; k < 1100; k++) begin
      if (k > 0) @(negedge clk);
      bad = (out_w !== OUT_W'(saw_val(k / 2)));
`ifdef OSC_MULTI_SYNC_EN
      bad |= (sync_w !== ((k % 2 == 0) && (k / 2 > 0) && ((k / 2) % (MAXV + 1) == 0)));
      if (sync_w === 1'b1) n++;
`endif
      if (bad) begin errs++; if (first < 0) first = k; end
    end
    check($sformatf("saw_ramp first_bad_cycle=%0d", first), errs, 0);
`ifdef OSC_MULTI_SYNC_EN
    check("saw_sync_count", n, 2);
`endif

    // Triangle, DIV=1, with STATUS polled every other cycle
    wr(32'h4, 32'(OSC_TRI), 4'hF);
    errs = 0; first = -1; st_exp = 0;
    for (int k = 0; k < 1040; k++) begin
      if (k > 0) @(negedge clk);
      n = k / 2;
      bad = (out_w !== OUT_W'(tri_val(n)));
      if (k >= 2 && k % 2 == 0) begin
        bad |= (bus.ready !== 1'b0);
        st_exp = 32'(tri_val(n)) | (32'(tri_down(n)) << 16) | 32'h0002_0000;
        bus.valid = 1'b1; bus.addr = 32'hC; bus.wstrb = 4'h0;
      end else if (k >= 3) begin
        bad |= (bus.ready !== 1'b1) || (bus.rdata !== st_exp);
        bus_idle();
      end
`ifdef OSC_MULTI_SYNC_EN
      bad |= (sync_w !== ((k % 2 == 0) && (n > 0) && (n % (2 * MAXV) == 0)));
`endif
      if (bad) begin errs++; if (first < 0) first = k; end
    end
    check($sformatf("tri_wave_status first_bad_cycle=%0d", first), errs, 0);

    // Square, DUTY=64 then 128 written mid-period without a phase reset
    wr(32'h8, 32'd64, 4'hF);
    wr(32'h4, 32'(OSC_SQR), 4'hF);
    duty = 64; mo = 0; n = 0; errs = 0; first = -1;
    for (int k = 0; k < 1600; k++) begin
      if (k > 0) @(negedge clk);
      bad = (out_w !== OUT_W'(mo));
`ifdef OSC_MULTI_SYNC_EN
      bad |= (sync_w !== ((k % 2 == 0) && (n > 0) && (n % (MAXV + 1) == 0)));
`endif
      if (k == 552) begin
        bus.valid = 1'b1; bus.addr = 32'h8; bus.wdata = 32'd128; bus.wstrb = 4'hF;
      end
      if (k == 553) begin
        bad |= (bus.ready !== 1'b1);
        bus_idle();
      end
      if (k % 2 == 1) begin
        n++;
        mo = ((n % (MAXV + 1)) < duty) ? MAXV : 0;
      end
      if (k == 552) duty = 128;
      if (bad) begin errs++; if (first < 0) first = k; end
    end
    check($sformatf("square_duty first_bad_cycle=%0d", first), errs, 0);

    // Square with DUTY=0 stays low
    wr(32'h8, 32'd0, 4'hF);
    wr(32'h4, 32'(OSC_SQR), 4'hF);
    errs = 0;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) @(negedge clk);
      if (out_w !== '0) errs++;
    end
    check("square_duty0_low", errs, 0);

    // DIV write in the same cycle as a tick: write wins, step dropped
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'(OSC_SAW), 4'hF);
    for (int k = 1; k <= 21; k++) @(negedge clk);
    check("collide_pre_out", out_w, 10);
    bus.valid = 1'b1; bus.addr = 32'h0; bus.wdata = 32'd1; bus.wstrb = 4'hF;
    @(negedge clk);
    check("collide_ready", bus.ready, 1);
    bus_idle();
    check("collide_out_c0", out_w, 0);
    @(negedge clk); check("collide_out_c1", out_w, 0);
    @(negedge clk); check("collide_out_c2", out_w, 1);
    @(negedge clk); check("collide_out_c3", out_w, 1);
    @(negedge clk); check("collide_out_c4", out_w, 2);

    // Reset mid-ramp at out=100
    wr(32'h8, 32'd33, 4'hF);
    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'(OSC_SAW), 4'hF);
    k_hit = 0;
    while (out_w !== OUT_W'(100) && k_hit < 400) begin
      @(negedge clk);
      k_hit++;
    end
    check("ramp_reached_100", out_w, 100);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_out", out_w, 0);
    check("midreset_ready", bus.ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), r);
      check($sformatf("midreset_reg%0d", i), r, 0);
    end

    // valid held high: ready alternates, one write per pulse
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = 32'h8; bus.wstrb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      bus.wdata = 32'(10 + k);
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", k + 1), bus.ready, (k % 2 == 0) ? 1 : 0);
    end
    bus_idle();
    rd(32'h8, r);
    check("b2b_last_write", r, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
